// File: rtl/hub75_pkg.sv
// hub75_pkg
//   Shared definitions for the HUB75 BCM scan driver:
//   - state_t      : scan FSM states
//   - IDX_*        : colour-field positions inside a frame-store word,
//                    packed {B1,G1,R1,B0,G0,R0}, each field PLANES bits wide
//   - field_base() : bit offset of a colour field inside that word
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_LATCH,
    ST_DISPLAY,
    ST_BLANK
  } state_t;

  localparam int IDX_R0     = 0;
  localparam int IDX_G0     = 1;
  localparam int IDX_B0     = 2;
  localparam int IDX_R1     = 3;
  localparam int IDX_G1     = 4;
  localparam int IDX_B1     = 5;
  localparam int NUM_FIELDS = 6;

  function automatic int field_base(input int idx, input int planes);
    return idx * planes;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer
//   Loadable down-counter used for every timed phase of the scan FSM.
//   Loading N-1 on phase entry makes done rise in the N-th cycle of the phase.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value loaded into the counter
//   done     : counter has reached zero
module hub75_bcm_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Counts down to zero and parks there until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver
//   HUB75 scan driver with binary-code-modulated colour depth. For every
//   row and bit plane it reads COLS pixel words from the frame store, shifts
//   the selected bit of each colour field into the panel, latches, then
//   enables the panel for OE_BASE<<plane cycles followed by a blank guard.
// Ports:
//   CLK_I, RST_N_I    : system clock, asynchronous active-low reset
//   EN_I              : run enable (checked in IDLE and at end of each plane)
//   PIX_RD_O          : frame-store read strobe
//   PIX_ADDR_O        : read address {row, col}
//   PIX_DATA_I        : read data, valid the cycle after PIX_RD_O
//   R0..B1            : serial colour data, top (0) and bottom (1) banks
//   ROW_O             : row demux address
//   CLK_O, LATCH, OE  : panel shift clock, latch (high), output enable (low)
//   FRAME_O           : one-cycle end-of-frame pulse
//   BUSY              : driver not idle
module hub75_bcm_driver #(
  parameter int COLS      = 32,
  parameter int ADDR_BITS = 4,
  parameter int PLANES    = 4,
  parameter int CLK_DIV   = 2,
  parameter int OE_BASE   = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic                                 CLK_I,
  input  logic                                 RST_N_I,
  input  logic                                 EN_I,
  output logic                                 PIX_RD_O,
  output logic [ADDR_BITS+$clog2(COLS)-1:0]    PIX_ADDR_O,
  input  logic [6*PLANES-1:0]                  PIX_DATA_I,
  output logic                                 R0,
  output logic                                 G0,
  output logic                                 B0,
  output logic                                 R1,
  output logic                                 G1,
  output logic                                 B1,
  output logic [ADDR_BITS-1:0]                 ROW_O,
  output logic                                 CLK_O,
  output logic                                 LATCH,
  output logic                                 OE,
  output logic                                 FRAME_O,
  output logic                                 BUSY
);

  import hub75_pkg::*;

  localparam int COL_W    = $clog2(COLS);
  localparam int PW       = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int DISP_MAX = OE_BASE << (PLANES - 1);
  localparam int TMAX     = (DISP_MAX > CLK_DIV)
                            ? ((DISP_MAX > BLANK_CYC) ? DISP_MAX : BLANK_CYC)
                            : ((CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC);
  localparam int TW       = $clog2(TMAX + 1);

  localparam logic [COL_W-1:0]     COL_LAST   = COL_W'(COLS - 1);
  localparam logic [PW-1:0]        PLANE_LAST = PW'(PLANES - 1);
  localparam logic [ADDR_BITS-1:0] ROW_LAST   = '1;

  state_t               state, state_next;
  logic [COL_W-1:0]     col;
  logic [PW-1:0]        plane;
  logic [ADDR_BITS-1:0] row;
  logic                 timer_load;
  logic [TW-1:0]        timer_val;
  logic                 timer_done;
  logic [NUM_FIELDS-1:0] plane_bits;
  logic [PLANES-1:0]    field_word;

  hub75_bcm_timer #(.W(TW)) u_timer (
    .clk      (CLK_I),
    .rst_n    (RST_N_I),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  assign PIX_ADDR_O = {row, col};

  // State register.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; EN_I only matters in IDLE and when a plane finishes.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (EN_I) state_next = ST_FETCH;
      ST_FETCH:   state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_CLK_LO;
      ST_CLK_LO:  if (timer_done) state_next = ST_CLK_HI;
      ST_CLK_HI:  if (timer_done) state_next = (col == COL_LAST) ? ST_LATCH : ST_FETCH;
      ST_LATCH:   state_next = ST_DISPLAY;
      ST_DISPLAY: if (timer_done) state_next = ST_BLANK;
      ST_BLANK:   if (timer_done) state_next = EN_I ? ST_FETCH : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // The phase timer is reloaded on every state change with the length of
  // the phase being entered; plane is stable until BLANK exit, so the
  // display length can be taken from it directly.
  always_comb begin
    timer_load = (state_next != state);
    timer_val  = '0;
    case (state_next)
      ST_CLK_LO, ST_CLK_HI: timer_val = TW'(CLK_DIV - 1);
      ST_DISPLAY:           timer_val = TW'((OE_BASE << plane) - 1);
      ST_BLANK:             timer_val = TW'(BLANK_CYC - 1);
      default:              timer_val = '0;
    endcase
  end

  // Pick bit 'plane' out of each colour field of the incoming pixel word.
  always_comb begin
    plane_bits = '0;
    field_word = '0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      field_word    = PIX_DATA_I[field_base(f, PLANES) +: PLANES] >> plane;
      plane_bits[f] = field_word[0];
    end
  end

  // Scan counters, colour shift registers and the row address. ROW_O is
  // loaded on entry to LATCH so it is settled before OE can go low.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      col   <= '0;
      plane <= '0;
      row   <= '0;
      ROW_O <= '0;
      R0    <= 1'b0;
      G0    <= 1'b0;
      B0    <= 1'b0;
      R1    <= 1'b0;
      G1    <= 1'b0;
      B1    <= 1'b0;
    end else begin
      if (state == ST_IDLE && EN_I) begin
        col   <= '0;
        plane <= '0;
        row   <= '0;
      end
      if (state == ST_CAPTURE) begin
        R0 <= plane_bits[IDX_R0];
        G0 <= plane_bits[IDX_G0];
        B0 <= plane_bits[IDX_B0];
        R1 <= plane_bits[IDX_R1];
        G1 <= plane_bits[IDX_G1];
        B1 <= plane_bits[IDX_B1];
      end
      if (state == ST_CLK_HI && timer_done) begin
        col <= (col == COL_LAST) ? '0 : col + 1'b1;
      end
      if (state_next == ST_LATCH && state != ST_LATCH) begin
        ROW_O <= row;
      end
      if (state == ST_BLANK && timer_done) begin
        if (plane == PLANE_LAST) begin
          plane <= '0;
          row   <= row + 1'b1;
        end else begin
          plane <= plane + 1'b1;
        end
      end
    end
  end

  // Panel and frame-store strobes decode straight from the state, so an
  // asynchronous reset blanks the panel without waiting for a clock.
  always_comb begin
    PIX_RD_O = 1'b0;
    CLK_O    = 1'b0;
    LATCH    = 1'b0;
    OE       = 1'b1;
    BUSY     = 1'b1;
    FRAME_O  = 1'b0;
    case (state)
      ST_IDLE:    BUSY     = 1'b0;
      ST_FETCH:   PIX_RD_O = 1'b1;
      ST_CLK_HI:  CLK_O    = 1'b1;
      ST_LATCH:   LATCH    = 1'b1;
      ST_DISPLAY: OE       = 1'b0;
      ST_BLANK:   FRAME_O  = timer_done && (plane == PLANE_LAST) && (row == ROW_LAST);
      default:    ;
    endcase
  end

endmodule
